// File: rtl/bram_stream_reader.sv
// Streams a contiguous BRAM address range out over a valid/ready interface.
// Absorbs the one-cycle BRAM read latency with a small credit-controlled FIFO.
module bram_stream_reader #(
  parameter int p_ADDRESS_WIDTH = 4,
  parameter int p_DATA_WIDTH    = 8
) (
  input  logic                       i_CLK,
  input  logic                       i_RESET,
  input  logic                       i_START,
  input  logic [p_ADDRESS_WIDTH-1:0] i_BASE_ADDRESS,
  input  logic [p_ADDRESS_WIDTH:0]   i_LENGTH,
  output logic                       o_BUSY,
  output logic                       o_DONE,
  output logic                       o_READ_ENABLE,
  output logic [p_ADDRESS_WIDTH-1:0] o_READ_ADDRESS,
  input  logic [p_DATA_WIDTH-1:0]    i_READ_DATA,
  output logic [p_DATA_WIDTH-1:0]    o_DATA,
  output logic                       o_VALID,
  output logic                       o_LAST,
  input  logic                       i_READY
);

  localparam int AW1 = p_ADDRESS_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t                     state, state_next;
  logic                       busy, busy_next;
  logic                       done, done_next;
  logic                       read_enable, read_enable_next;
  logic [p_ADDRESS_WIDTH-1:0] read_address, read_address_next;
  logic [AW1-1:0]             length, length_next;
  logic [AW1-1:0]             issued, issued_next;
  logic [AW1-1:0]             remaining, remaining_next;
  logic                       pending;

  logic [p_DATA_WIDTH-1:0]    fifo_mem [4];
  logic [1:0]                 wr_ptr, rd_ptr;
  logic [2:0]                 fifo_count;
  logic [3:0]                 in_use;
  logic                       credit, push, pop, valid, last;

  // Words already buffered plus those still on their way from the BRAM.
  assign in_use = {1'b0, fifo_count} + {3'b000, read_enable} + {3'b000, pending};
  assign credit = in_use < 4'd4;
  assign push   = pending;
  assign valid  = fifo_count != 3'd0;
  assign pop    = valid && i_READY;
  assign last   = valid && (remaining == AW1'(1));

  always_comb begin
    state_next        = state;
    busy_next         = busy;
    done_next         = 1'b0;
    read_enable_next  = 1'b0;
    read_address_next = read_address;
    length_next       = length;
    issued_next       = issued;
    remaining_next    = pop ? remaining - AW1'(1) : remaining;
    case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (i_START) begin
          length_next    = i_LENGTH;
          remaining_next = i_LENGTH;
          busy_next      = 1'b1;
          if (i_LENGTH == '0) begin
            state_next = FINISH;
          end else begin
            state_next        = READ;
            read_enable_next  = 1'b1;
            read_address_next = i_BASE_ADDRESS;
            issued_next       = AW1'(1);
          end
        end
      end
      READ: begin
        if (issued == length) begin
          state_next = DRAIN;
        end else if (credit) begin
          read_enable_next  = 1'b1;
          read_address_next = read_address + p_ADDRESS_WIDTH'(1);
          issued_next       = issued + AW1'(1);
        end
      end
      DRAIN: begin
        if (pop && last) begin
          state_next = FINISH;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      FINISH: begin
        // A zero-length start arrives here with busy still high; spend one
        // extra cycle so the done pulse follows the busy cycle.
        busy_next = 1'b0;
        if (done) begin
          state_next = IDLE;
        end else begin
          done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      read_enable  <= 1'b0;
      read_address <= '0;
      length       <= '0;
      issued       <= '0;
      remaining    <= '0;
      pending      <= 1'b0;
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      fifo_count   <= 3'd0;
    end else begin
      state        <= state_next;
      busy         <= busy_next;
      done         <= done_next;
      read_enable  <= read_enable_next;
      read_address <= read_address_next;
      length       <= length_next;
      issued       <= issued_next;
      remaining    <= remaining_next;
      pending      <= read_enable;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (push) fifo_mem[wr_ptr] <= i_READ_DATA;
  end

  assign o_BUSY         = busy;
  assign o_DONE         = done;
  assign o_READ_ENABLE  = read_enable;
  assign o_READ_ADDRESS = read_address;
  assign o_VALID        = valid;
  assign o_LAST         = last;
  // Gated so stale FIFO contents never appear (and reset shows zero).
  assign o_DATA         = valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed table-driven bench for bram_stream_reader with a behavioural BRAM
// (mem[a] = a + 8'h10, one-cycle read latency, returns 0 when not enabled).
module tb_bram_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] base = 4'd0;
  logic [4:0] len = 5'd0;
  logic       busy, done, rd_en, valid, last;
  logic       ready = 1'b0;
  logic [3:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] data;
  logic [7:0] mem [16];

  int checks = 0;
  int failures = 0;

  bram_stream_reader #(.p_ADDRESS_WIDTH(4), .p_DATA_WIDTH(8)) dut (
    .i_CLK(clk), .i_RESET(rst), .i_START(start), .i_BASE_ADDRESS(base),
    .i_LENGTH(len), .o_BUSY(busy), .o_DONE(done), .o_READ_ENABLE(rd_en),
    .o_READ_ADDRESS(rd_addr), .i_READ_DATA(rd_data), .o_DATA(data),
    .o_VALID(valid), .o_LAST(last), .i_READY(ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'h00;

  typedef struct {
    logic [3:0] base;
    logic [4:0] len;
    int         ready_mode;     // 0: always ready, 1: stalled 10 cycles then toggling
    bit         restart;        // pulse a second start mid-transfer
    int         exp_words;
    int         exp_reads;
    int         exp_first_data;
    int         exp_last_data;
    int         exp_first_valid;
    int         exp_done_cyc;
    int         exp_busy_cycles;
    int         exp_reads_before_pop;
    int         exp_first_addr;
    int         exp_last_addr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int reads = 0, words = 0, first_valid = -1, done_cyc = -1, done_cnt = 0;
    int busy_cnt = 0, first_data = -1, last_data = -1, rbp = -1;
    int first_addr = -1, last_addr = -1;
    int addr_err = 0, data_err = 0, last_err = 0, hold_err = 0, done_busy_err = 0;
    bit prev_stall = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = 8'h00;
    @(negedge clk);
    base = v.base; len = v.len; start = 1'b1; ready = (v.ready_mode == 0);
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      start = v.restart && (cyc == 3);
      if (start) begin base = 4'd9; len = 5'd3; end
      if (v.ready_mode == 0) ready = 1'b1;
      else ready = (cyc >= 10) && (((cyc - 10) % 2) == 0);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy) done_busy_err++;
      end
      if (rd_en) begin
        if (int'(rd_addr) != ((int'(v.base) + reads) % 16)) addr_err++;
        if (reads == 0) first_addr = int'(rd_addr);
        last_addr = int'(rd_addr);
        reads++;
      end
      if (valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!valid || data != prev_data || last != prev_last)) hold_err++;
      if (valid && ready) begin
        if (words == 0) begin first_data = int'(data); rbp = reads; end
        last_data = int'(data);
        if (int'(data) != 16 + ((int'(v.base) + words) % 16)) data_err++;
        if (last != (words == int'(v.len) - 1)) last_err++;
        words++;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_last  = last;
    end
    start = 1'b0;
    if (rbp < 0) rbp = reads;
    $display("vec%0d base=%0d len=%0d words=%0d reads=%0d first_valid=%0d done_cyc=%0d",
             idx, v.base, v.len, words, reads, first_valid, done_cyc);
    check($sformatf("vec%0d_words", idx), words, v.exp_words);
    check($sformatf("vec%0d_reads", idx), reads, v.exp_reads);
    check($sformatf("vec%0d_first_valid", idx), first_valid, v.exp_first_valid);
    check($sformatf("vec%0d_done_cyc", idx), done_cyc, v.exp_done_cyc);
    check($sformatf("vec%0d_done_cnt", idx), done_cnt, 1);
    check($sformatf("vec%0d_busy_cycles", idx), busy_cnt, v.exp_busy_cycles);
    check($sformatf("vec%0d_reads_before_pop", idx), rbp, v.exp_reads_before_pop);
    check($sformatf("vec%0d_addr_err", idx), addr_err, 0);
    check($sformatf("vec%0d_data_err", idx), data_err, 0);
    check($sformatf("vec%0d_last_err", idx), last_err, 0);
    check($sformatf("vec%0d_hold_err", idx), hold_err, 0);
    check($sformatf("vec%0d_done_busy", idx), done_busy_err, 0);
    if (v.exp_words > 0) begin
      check($sformatf("vec%0d_first_data", idx), first_data, v.exp_first_data);
      check($sformatf("vec%0d_last_data", idx), last_data, v.exp_last_data);
    end
    if (v.exp_reads > 0) begin
      check($sformatf("vec%0d_first_addr", idx), first_addr, v.exp_first_addr);
      check($sformatf("vec%0d_last_addr", idx), last_addr, v.exp_last_addr);
    end
  endtask

  initial begin
    int hs;
    int stray;
    for (int a = 0; a < 16; a++) mem[a] = 8'(a + 16);

    //         base   len    rdy rst words reads fd     ld     fv done busy rbp fa  la
    vecs[0] = '{4'd2,  5'd4,  0, 0, 4,  4,  'h12, 'h15, 2,  6,  6,  3, 2,  5};
    vecs[1] = '{4'd14, 5'd4,  0, 0, 4,  4,  'h1E, 'h11, 2,  6,  6,  3, 14, 1};
    vecs[2] = '{4'd0,  5'd16, 1, 0, 16, 16, 'h10, 'h1F, 2,  41, 41, 4, 0,  15};
    vecs[3] = '{4'd7,  5'd0,  0, 0, 0,  0,  0,    0,    -1, 1,  1,  0, 0,  0};
    vecs[4] = '{4'd3,  5'd8,  0, 1, 8,  8,  'h13, 'h1A, 2,  10, 10, 3, 3,  10};
    vecs[5] = '{4'd5,  5'd2,  0, 0, 2,  2,  'h15, 'h16, 2,  4,  4,  2, 5,  6};

    repeat (3) @(negedge clk);
    #1;
    $display("reset state busy=%0d done=%0d rd_en=%0d valid=%0d", busy, done, rd_en, valid);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_rd_en", int'(rd_en), 0);
    check("reset_rd_addr", int'(rd_addr), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_last", int'(last), 0);
    check("reset_data", int'(data), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Reset after the third handshake of a length-8 transfer.
    @(negedge clk);
    base = 4'd0; len = 5'd8; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int g = 0; g < 30 && hs < 3; g++) begin
      #1;
      if (valid) hs++;
      if (hs < 3) @(negedge clk);
    end
    check("rst_handshakes_reached", hs, 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("mid-transfer reset busy=%0d valid=%0d rd_en=%0d data=%0h", busy, valid, rd_en, data);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_rd_en", int'(rd_en), 0);
    check("midrst_rd_addr", int'(rd_addr), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_last", int'(last), 0);
    check("midrst_data", int'(data), 0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (done || valid || rd_en || busy) stray++;
    end
    check("midrst_no_activity", stray, 0);

    run_vec(vecs[5], 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
